// File: rtl/servus_rst_pkg.sv
// Shared definitions for the core reset sequencer and the clock-monitor block:
// state encodings and the sizing rule for the qualification and hold counters.
package servus_rst_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_HOLD      = ST_HOLD,
    S_RUN       = ST_RUN
  } rst_state_e;

  // One extra bit above the largest terminal count, so the counter never wraps.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/servus_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level signal.
// Asynchronous active-low clear to 0.
module servus_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], i_d};
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/servus_rst_seq.sv
// Core reset sequencer: qualifies MMCM lock in the generated clock domain,
// holds reset for a fixed time after lock, and re-enters reset on lock loss or software request.
module servus_rst_seq
  import servus_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_locked,
  input  logic             i_sw_rst,
  output logic             o_rst,
  output logic             o_rst_done,
  output logic [CNT_W-1:0] o_lock_loss_cnt
);

  localparam int CW = cnt_width(LOCK_STABLE, HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CW_ONE      = CW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic          locked_s;
  rst_state_e    state, next_state;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] hold_cnt;

  servus_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (locked_s)
  );

  // Lock loss beats software reset, which beats hold expiry.
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT_LOCK: if (locked_s && stable_cnt == STABLE_LAST) next_state = S_HOLD;
      S_HOLD: begin
        if (!locked_s)                    next_state = S_WAIT_LOCK;
        else if (i_sw_rst)                next_state = S_HOLD;
        else if (hold_cnt == HOLD_LAST)   next_state = S_RUN;
      end
      S_RUN: begin
        if (!locked_s)      next_state = S_WAIT_LOCK;
        else if (i_sw_rst)  next_state = S_HOLD;
      end
      default: next_state = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_WAIT_LOCK;
      stable_cnt      <= '0;
      hold_cnt        <= '0;
      o_rst           <= 1'b1;
      o_rst_done      <= 1'b0;
      o_lock_loss_cnt <= '0;
    end else begin
      state      <= next_state;
      o_rst      <= (next_state != S_RUN);
      o_rst_done <= (next_state == S_RUN) && (state != S_RUN);
      case (state)
        S_WAIT_LOCK: begin
          if (!locked_s) begin
            stable_cnt <= '0;
          end else if (next_state == S_HOLD) begin
            stable_cnt <= '0;
            hold_cnt   <= '0;
          end else begin
            stable_cnt <= stable_cnt + CW_ONE;
          end
        end
        S_HOLD: begin
          if (!locked_s)     stable_cnt <= '0;
          else if (i_sw_rst) hold_cnt   <= '0;
          else               hold_cnt   <= hold_cnt + CW_ONE;
        end
        S_RUN: begin
          // Only lock losses seen while running are counted; the count saturates.
          if (!locked_s) begin
            stable_cnt <= '0;
            if (o_lock_loss_cnt != '1) o_lock_loss_cnt <= o_lock_loss_cnt + CNT_ONE;
          end else if (i_sw_rst) begin
            hold_cnt <= '0;
          end
        end
        default: stable_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_servus_rst_seq.sv
// Directed bench for servus_rst_seq: release latency, lock glitches, lock loss,
// software reset, counter saturation and asynchronous reset.
module tb_servus_rst_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_locked = 1'b0;
  logic       i_locked2 = 1'b0;
  logic       i_sw_rst = 1'b0;
  logic       o_rst, o_rst_done, o_rst2, o_rst_done2;
  logic [7:0] o_lock_loss_cnt;
  logic [1:0] o_lock_loss_cnt2;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  servus_rst_seq dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_locked        (i_locked),
    .i_sw_rst        (i_sw_rst),
    .o_rst           (o_rst),
    .o_rst_done      (o_rst_done),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  servus_rst_seq #(.CNT_W(2)) dut2 (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_locked        (i_locked2),
    .i_sw_rst        (i_sw_rst),
    .o_rst           (o_rst2),
    .o_rst_done      (o_rst_done2),
    .o_lock_loss_cnt (o_lock_loss_cnt2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Hold reset for two edges, then release it 1 ns after an edge with the given lock level.
  task automatic apply_reset(input logic locked);
    i_rst_n = 1'b0;
    step(2);
    i_locked = locked;
    i_rst_n  = 1'b1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    #1;
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_o_rst: got %b expected 1", o_rst); end
    total++; if (o_rst_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_rst_done: got %b expected 0", o_rst_done); end
    total++; if (o_lock_loss_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d expected 0", o_lock_loss_cnt); end
    total++; if (o_rst2 !== 1'b1) begin bad++; $display("[TB] FAIL reset_o_rst2: got %b expected 1", o_rst2); end
  endtask

  task automatic test_release;
    apply_reset(1'b1);
    step(25);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL release_edge25_rst: got %b expected 1", o_rst); end
    total++; if (o_rst_done !== 1'b0) begin bad++; $display("[TB] FAIL release_edge25_done: got %b expected 0", o_rst_done); end
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL release_edge26_rst: got %b expected 0", o_rst); end
    total++; if (o_rst_done !== 1'b1) begin bad++; $display("[TB] FAIL release_edge26_done: got %b expected 1", o_rst_done); end
    total++; if (o_lock_loss_cnt !== 8'd0) begin bad++; $display("[TB] FAIL release_cnt: got %0d expected 0", o_lock_loss_cnt); end
    step(1);
    total++; if (o_rst_done !== 1'b0) begin bad++; $display("[TB] FAIL release_edge27_done: got %b expected 0", o_rst_done); end
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL release_edge27_rst: got %b expected 0", o_rst); end
  endtask

  // Lock drops for three cycles once stable_cnt has reached 10 (after edge 12).
  task automatic test_glitch;
    apply_reset(1'b1);
    step(12);
    i_locked = 1'b0;
    step(3);
    i_locked = 1'b1;
    step(11);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL glitch_no_early_release: got %b expected 1", o_rst); end
    step(14);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL glitch_edge40_rst: got %b expected 1", o_rst); end
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL glitch_edge41_rst: got %b expected 0", o_rst); end
    total++; if (o_rst_done !== 1'b1) begin bad++; $display("[TB] FAIL glitch_edge41_done: got %b expected 1", o_rst_done); end
    total++; if (o_lock_loss_cnt !== 8'd0) begin bad++; $display("[TB] FAIL glitch_cnt: got %0d expected 0", o_lock_loss_cnt); end
    step(1);
  endtask

  task automatic test_lock_loss;
    i_locked = 1'b0;
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL loss_early_rst: got %b expected 0", o_rst); end
    step(2);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL loss_rst: got %b expected 1", o_rst); end
    total++; if (o_lock_loss_cnt !== 8'd1) begin bad++; $display("[TB] FAIL loss_cnt: got %0d expected 1", o_lock_loss_cnt); end
    i_locked = 1'b1;
    step(25);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL relock_edge25_rst: got %b expected 1", o_rst); end
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL relock_edge26_rst: got %b expected 0", o_rst); end
    total++; if (o_rst_done !== 1'b1) begin bad++; $display("[TB] FAIL relock_edge26_done: got %b expected 1", o_rst_done); end
    step(1);
  endtask

  task automatic test_sw_rst;
    i_sw_rst = 1'b1;
    step(1);
    i_sw_rst = 1'b0;
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL swrst_assert: got %b expected 1", o_rst); end
    step(7);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL swrst_hold8: got %b expected 1", o_rst); end
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL swrst_release: got %b expected 0", o_rst); end
    total++; if (o_rst_done !== 1'b1) begin bad++; $display("[TB] FAIL swrst_done: got %b expected 1", o_rst_done); end
    step(1);
    // Second request four edges into the hold restarts the count from zero.
    i_sw_rst = 1'b1;
    step(1);
    i_sw_rst = 1'b0;
    step(4);
    i_sw_rst = 1'b1;
    step(1);
    i_sw_rst = 1'b0;
    step(3);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL swrst_restart_held: got %b expected 1", o_rst); end
    step(4);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL swrst_restart_edge12: got %b expected 1", o_rst); end
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL swrst_restart_release: got %b expected 0", o_rst); end
    total++; if (o_rst_done !== 1'b1) begin bad++; $display("[TB] FAIL swrst_restart_done: got %b expected 1", o_rst_done); end
    total++; if (o_lock_loss_cnt !== 8'd1) begin bad++; $display("[TB] FAIL swrst_cnt_kept: got %0d expected 1", o_lock_loss_cnt); end
    step(1);
  endtask

  task automatic test_saturate;
    logic [1:0] exp_cnt;
    for (int i = 1; i <= 5; i++) begin
      i_locked2 = 1'b1;
      step(26);
      total++; if (o_rst2 !== 1'b0) begin bad++; $display("[TB] FAIL sat_run_%0d: got %b expected 0", i, o_rst2); end
      i_locked2 = 1'b0;
      step(3);
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      total++; if (o_lock_loss_cnt2 !== exp_cnt) begin bad++; $display("[TB] FAIL sat_cnt_%0d: got %0d expected %0d", i, o_lock_loss_cnt2, exp_cnt); end
    end
  endtask

  task automatic test_async_reset;
    i_sw_rst = 1'b1;
    step(1);
    i_sw_rst = 1'b0;
    step(3);
    #3;
    i_rst_n = 1'b0;
    #1;
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL async_rst: got %b expected 1", o_rst); end
    total++; if (o_lock_loss_cnt !== 8'd0) begin bad++; $display("[TB] FAIL async_cnt: got %0d expected 0", o_lock_loss_cnt); end
    total++; if (o_lock_loss_cnt2 !== 2'd0) begin bad++; $display("[TB] FAIL async_cnt2: got %0d expected 0", o_lock_loss_cnt2); end
    step(1);
    i_rst_n = 1'b1;
    step(25);
    total++; if (o_rst !== 1'b1) begin bad++; $display("[TB] FAIL async_edge25_rst: got %b expected 1", o_rst); end
    step(1);
    total++; if (o_rst !== 1'b0) begin bad++; $display("[TB] FAIL async_edge26_rst: got %b expected 0", o_rst); end
    total++; if (o_rst_done !== 1'b1) begin bad++; $display("[TB] FAIL async_edge26_done: got %b expected 1", o_rst_done); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step(1);
    test_reset;
    test_release;
    test_glitch;
    test_lock_loss;
    test_sw_rst;
    test_saturate;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
